// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM states,
// the excitation table and FIFO pointer sizing.
package jk_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2
   } state_e;

   localparam int unsigned DEPTH_DEF = 8;
   localparam int unsigned PTR_W_DEF = $clog2(DEPTH_DEF) + 1;

   // Pointer width carries one extra wrap bit to tell full from empty.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Returns {J, K} that moves a JK flip-flop from q to t; dc fills the free input.
   function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
      logic [1:0] jk;
      case ({q, t})
         2'b00:   jk = {1'b0, dc};
         2'b01:   jk = {1'b1, dc};
         2'b10:   jk = {dc, 1'b1};
         2'b11:   jk = {dc, 1'b0};
         default: jk = 2'b00;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_bit_fifo.sv
// One-bit-wide synchronous FIFO; a pushed bit becomes visible at the head
// one edge later. Pointers wrap modulo DEPTH with an extra wrap bit.
module jk_bit_fifo
   import jk_drv_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned AW = PW - 1;

   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [DEPTH-1:0] mem_q;
   logic             do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K of a JK flip-flop toward a stream of buffered target bits and
// checks the returned Q one cycle after each apply, counting mismatches.
module jk_excitation_driver
   import jk_drv_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned CNT_W  = 8,
   parameter bit          DC_VAL = 1'b0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   input  logic             IN_BIT,
   output logic             IN_READY,
   input  logic             Q,
   output logic             J,
   output logic             K,
   output logic             BUSY,
   output logic             MISMATCH,
   output logic [CNT_W-1:0] ERR_CNT,
   input  logic             CLR_ERR
);

   state_e           state_q, state_d;
   logic             t_q, t_d;
   logic             j_q, j_d;
   logic             k_q, k_d;
   logic             mism_q, mism_d;
   logic [CNT_W-1:0] err_q, err_d;

   logic             fifo_pop, fifo_head, fifo_full, fifo_empty;
   logic             load;
   logic [1:0]       jk_next;

   jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .push_i  (IN_VALID),
      .din_i   (IN_BIT),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign jk_next = jk_excite(Q, fifo_head, DC_VAL);
   assign load    = (state_q != APPLY) && !fifo_empty;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      j_d      = 1'b0;
      k_d      = 1'b0;
      mism_d   = 1'b0;
      fifo_pop = 1'b0;
      unique case (state_q)
         IDLE:    if (load) state_d = APPLY;
         APPLY:   state_d = CHECK;
         CHECK: begin
            mism_d  = (Q != t_q);
            state_d = load ? APPLY : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         fifo_pop   = 1'b1;
         t_d        = fifo_head;
         {j_d, k_d} = jk_next;
      end
   end

   // Clear beats a coincident increment; the pulse itself is unaffected.
   always_comb begin
      err_d = err_q;
      if (CLR_ERR)                         err_d = '0;
      else if (mism_d && (err_q != '1))    err_d = err_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         t_q     <= 1'b0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         mism_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         j_q     <= j_d;
         k_q     <= k_d;
         mism_q  <= mism_d;
         err_q   <= err_d;
      end
   end

   assign J        = j_q;
   assign K        = k_q;
   assign MISMATCH = mism_q;
   assign ERR_CNT  = err_q;
   assign IN_READY = !fifo_full;
   assign BUSY     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: a scoreboard of predicted J/K/MISMATCH per target bit is
// filled at drive time and consumed by a cycle monitor as the DUT pops bits.
module tb_jk_excitation_driver;

   localparam int DEPTH   = 8;
   localparam int ERR_MAX = 255;

   typedef struct packed {
      logic t;
      logic j;
      logic k;
      logic m;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, in_valid, in_bit, clr_err, in_ready;
   logic       q, j, k, busy, mismatch;
   logic [7:0] err_cnt;

   logic       in_valid2, in_bit2, in_ready2, q2, j2, k2, busy2, mism2;
   logic [1:0] err2;

   logic ff_q, stuck_en, ff2_q, ff2_set, stuck2;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   m_pulses = 0;
   bit   mon_en   = 1'b0;
   logic q_pred;

   rec_t sb_in[$];
   rec_t mdl_fifo[$];

   jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(8), .DC_VAL(1'b0)) u_dut (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_BIT(in_bit),
      .IN_READY(in_ready), .Q(q), .J(j), .K(k), .BUSY(busy),
      .MISMATCH(mismatch), .ERR_CNT(err_cnt), .CLR_ERR(clr_err)
   );

   jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(2), .DC_VAL(1'b1)) u_dut2 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid2), .IN_BIT(in_bit2),
      .IN_READY(in_ready2), .Q(q2), .J(j2), .K(k2), .BUSY(busy2),
      .MISMATCH(mism2), .ERR_CNT(err2), .CLR_ERR(1'b0)
   );

   // Behavioural JK flip-flops; Q can be disconnected and held at 0.
   assign q  = stuck_en ? 1'b0 : ff_q;
   assign q2 = stuck2 ? 1'b0 : ff2_q;

   always @(posedge clk) begin
      if (!rst_n) ff_q <= 1'b0;
      else case ({j, k})
         2'b01:   ff_q <= 1'b0;
         2'b10:   ff_q <= 1'b1;
         2'b11:   ff_q <= ~ff_q;
         default: ff_q <= ff_q;
      endcase
   end

   always @(posedge clk) begin
      if (!rst_n)       ff2_q <= 1'b0;
      else if (ff2_set) ff2_q <= 1'b1;
      else case ({j2, k2})
         2'b01:   ff2_q <= 1'b0;
         2'b10:   ff2_q <= 1'b1;
         2'b11:   ff2_q <= ~ff2_q;
         default: ff2_q <= ff2_q;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Excitation table for DC_VAL=0; a stuck-at-0 Q fails only targets of 1.
   function automatic rec_t make_rec(input logic qp, input logic t, input logic stuck);
      rec_t r;
      r.t = t;
      case ({qp, t})
         2'b01:   {r.j, r.k} = 2'b10;
         2'b10:   {r.j, r.k} = 2'b01;
         default: {r.j, r.k} = 2'b00;
      endcase
      r.m = stuck && t;
      return r;
   endfunction

   task automatic push_bit(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      for (int w = 0; w < 50 && in_ready !== 1'b1; w++) tick();
      check("push_ready", in_ready, 1);
      sb_in.push_back(make_rec(q_pred, b, stuck_en));
      q_pred = stuck_en ? 1'b0 : b;
      tick();
   endtask

   task automatic wait_idle(input string tag);
      in_valid = 1'b0;
      for (int w = 0; w < 3000 && busy !== 1'b0; w++) tick();
      check({"idle_", tag}, busy, 0);
      tick();
   endtask

   // Cycle monitor: tracks occupancy and phase, pops scoreboard entries.
   initial begin
      int   phase;
      logic s_rst, s_v, s_clr, push_ok, ej, ek, em;
      int   eerr;
      rec_t cur;
      phase = 0; ej = 0; ek = 0; em = 0; eerr = 0; cur = '0;
      forever begin
         @(posedge clk);
         s_rst = rst_n; s_v = in_valid; s_clr = clr_err;
         if (s_rst !== 1'b1) begin
            mdl_fifo.delete();
            sb_in.delete();
            phase = 0; ej = 0; ek = 0; em = 0; eerr = 0;
         end else begin
            push_ok = s_v && (mdl_fifo.size() < DEPTH);
            em = (phase == 2) && cur.m;
            if (s_clr)                        eerr = 0;
            else if (em && eerr < ERR_MAX)    eerr++;
            ej = 0; ek = 0;
            if (phase == 1) phase = 2;
            else if (mdl_fifo.size() > 0) begin
               cur   = mdl_fifo.pop_front();
               ej    = cur.j;
               ek    = cur.k;
               phase = 1;
            end else phase = 0;
            if (push_ok && sb_in.size() > 0) mdl_fifo.push_back(sb_in.pop_front());
         end
         #1;
         if (mon_en) begin
            check("mon_J", j, ej);
            check("mon_K", k, ek);
            check("mon_MISMATCH", mismatch, em);
            check("mon_ERR_CNT", err_cnt, eerr);
            check("mon_IN_READY", in_ready, mdl_fifo.size() < DEPTH);
            check("mon_BUSY", busy, (phase != 0) || (mdl_fifo.size() > 0));
            if (mismatch === 1'b1) m_pulses++;
         end
      end
   end

   initial begin
      int base;
      rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_err = 1'b0;
      in_valid2 = 1'b0; in_bit2 = 1'b0; ff2_set = 1'b0; stuck2 = 1'b0;
      stuck_en = 1'b0; q_pred = 1'b0;

      // Reset state
      tick();
      mon_en = 1'b1;
      tick();
      check("rst_J", j, 0);
      check("rst_K", k, 0);
      check("rst_MISMATCH", mismatch, 0);
      check("rst_ERR_CNT", err_cnt, 0);
      check("rst_IN_READY", in_ready, 1);
      check("rst_BUSY", busy, 0);
      rst_n = 1'b1;
      tick();

      // Normal sequence 1,0,0,1 from Q=0
      base = m_pulses;
      push_bit(1'b1); push_bit(1'b0); push_bit(1'b0); push_bit(1'b1);
      wait_idle("seq");
      check("seq_Q_final", q, 1);
      check("seq_no_mismatch", m_pulses - base, 0);
      check("seq_ERR_CNT", err_cnt, 0);

      // Back-to-back pushes fill the FIFO after 15 accepted bits
      for (int i = 0; i < 15; i++) push_bit(i[0]);
      check("fill_IN_READY_low", in_ready, 0);
      for (int i = 0; i < 5; i++) push_bit(~i[0]);
      wait_idle("fill");

      // Q stuck at 0: three failed targets
      stuck_en = 1'b1;
      q_pred   = 1'b0;
      tick();
      base = m_pulses;
      push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
      wait_idle("stuck");
      check("stuck_pulses", m_pulses - base, 3);
      check("stuck_ERR_CNT", err_cnt, 3);

      // Clear coinciding with an increment
      push_bit(1'b1);
      in_valid = 1'b0;
      tick();
      tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_MISMATCH", mismatch, 1);
      check("clr_ERR_CNT", err_cnt, 0);
      wait_idle("clr");

      // Saturation at 2^8-1
      base = m_pulses;
      for (int i = 0; i < 258; i++) push_bit(1'b1);
      wait_idle("sat");
      check("sat_ERR_CNT", err_cnt, 255);
      check("sat_pulses", m_pulses - base, 258);

      // Reset during APPLY with four bits buffered
      stuck_en = 1'b0;
      tick();
      q_pred = q;
      push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
      push_bit(1'b0); push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("mid_rst_J", j, 0);
      check("mid_rst_K", k, 0);
      check("mid_rst_BUSY", busy, 0);
      check("mid_rst_IN_READY", in_ready, 1);
      check("mid_rst_ERR_CNT", err_cnt, 0);
      rst_n  = 1'b1;
      q_pred = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_BUSY", busy, 0);
      check("post_rst_J", j, 0);

      // Second instance: DC_VAL=1, Q=1, target 1
      ff2_set = 1'b1;
      tick();
      ff2_set = 1'b0;
      check("dc_Q_start", q2, 1);
      in_valid2 = 1'b1; in_bit2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      tick();
      check("dc_J", j2, 1);
      check("dc_K", k2, 0);
      tick();
      check("dc_J_release", j2, 0);
      check("dc_K_release", k2, 0);
      check("dc_Q_hold", q2, 1);
      tick();
      check("dc_MISMATCH", mism2, 0);
      check("dc_BUSY", busy2, 0);

      // Second instance: 2-bit counter saturates at 3 after five failures
      stuck2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid2 = 1'b1; in_bit2 = 1'b1;
         for (int w = 0; w < 50 && in_ready2 !== 1'b1; w++) tick();
         check("sat2_ready", in_ready2, 1);
         tick();
      end
      in_valid2 = 1'b0;
      for (int w = 0; w < 200 && busy2 !== 1'b0; w++) tick();
      check("sat2_idle", busy2, 0);
      check("sat2_ERR_CNT", err2, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
